// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between the CPU control unit (port 0) and a
// secondary requester such as a loader, debug or DMA engine (port 1).
//
// Port 0 always has priority. It drives the memory bus combinationally, so it
// adds no latency and never stalls. Port 1 only uses cycles in which port 0 is
// idle. A three-state FSM (IDLE / REQ / RDWAIT) keeps port 1 to one outstanding
// access at a time.
//
// Read data is steered back to its requester by a tag pipeline {valid, owner}.
// The pipeline has the same depth as the memory read latency.
//
// Optional feature, enabled by the macro DMEM_ARB_STARVE_MON_EN:
//   p1_wait_max [15:0]  longest run of consecutive REQ cycles since reset;
//                       saturates at 0xFFFF.
//   p1_starved          sticky flag, set once a run reaches 256 cycles;
//                       cleared only by rst.
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   D_addr/D_rd/D_wr/cpu_wdata     port 0 request
//   cpu_rdata/cpu_rvalid           port 0 read return (passthrough of mem_rdata)
//   p1_req/p1_we/p1_addr/p1_wdata  port 1 request, held until p1_gnt
//   p1_gnt                         port 1 issue pulse (combinational)
//   p1_rdata/p1_rvalid             port 1 read return (registered)
//   p1_busy                        port 1 FSM not in IDLE
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata   memory bus
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic              D_rd,
    input  logic              D_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              p1_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STARVE_MON_EN
    ,
    output logic [15:0]       p1_wait_max,
    output logic              p1_starved
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              w_cpu_active;
    logic              w_issue;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_own;
    logic              w_tag_out_vld;
    logic              w_tag_out_own;
    logic              w_p1_ret;
    logic              r_p1_rvalid;
    logic [DATA_W-1:0] r_p1_rdata;

    assign w_cpu_active = D_rd | D_wr;
    // Port 1 issues only from REQ, while still requesting, on a cycle the CPU leaves free.
    assign w_issue      = (r_state == S_REQ) & p1_req & ~w_cpu_active & ~rst;

    // Memory bus mux. Address and data hold their last driven value when nobody issues.
    always_comb begin
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        mem_addr  = r_addr_hold;
        mem_wdata = r_wdata_hold;
        if (w_cpu_active) begin
            mem_addr  = D_addr;
            mem_wdata = cpu_wdata;
        end else if (w_issue) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
        if (!rst) begin
            if (w_cpu_active) begin
                // When both strobes are high, the write wins and the read is dropped.
                w_mem_wr = D_wr;
                w_mem_rd = D_rd & ~D_wr;
            end else if (w_issue) begin
                w_mem_wr = p1_we;
                w_mem_rd = ~p1_we;
            end
        end
    end

    assign mem_rd = w_mem_rd;
    assign mem_wr = w_mem_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else if (w_cpu_active || w_issue) begin
            r_addr_hold  <= mem_addr;
            r_wdata_hold <= mem_wdata;
        end
    end

    // Tag pipeline. Stage RD_LAT-1 lines up with mem_rdata for the read it tracks.
    // Owner 1 means port 1; any read issued while the CPU is idle belongs to port 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld[0] <= 1'b0;
            r_tag_own[0] <= 1'b0;
        end else begin
            r_tag_vld[0] <= w_mem_rd;
            r_tag_own[0] <= ~w_cpu_active;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_vld[gi] <= 1'b0;
                    r_tag_own[gi] <= 1'b0;
                end else begin
                    r_tag_vld[gi] <= r_tag_vld[gi-1];
                    r_tag_own[gi] <= r_tag_own[gi-1];
                end
            end
        end
    endgenerate

    assign w_tag_out_vld = r_tag_vld[RD_LAT-1];
    assign w_tag_out_own = r_tag_own[RD_LAT-1];
    assign w_p1_ret      = w_tag_out_vld & w_tag_out_own;

    assign cpu_rdata  = mem_rdata;
    assign cpu_rvalid = w_tag_out_vld & ~w_tag_out_own & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_rvalid <= 1'b0;
            r_p1_rdata  <= '0;
        end else begin
            r_p1_rvalid <= w_p1_ret;
            if (w_p1_ret) begin
                r_p1_rdata <= mem_rdata;
            end
        end
    end

    assign p1_rvalid = r_p1_rvalid;
    assign p1_rdata  = r_p1_rdata;

    // Port 1 FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (p1_req) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!p1_req) begin
                    w_state_next = S_IDLE;
                end else if (w_issue) begin
                    w_state_next = p1_we ? S_IDLE : S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (w_p1_ret) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign p1_gnt  = w_issue;
    assign p1_busy = (r_state != S_IDLE);

`ifdef DMEM_ARB_STARVE_MON_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] r_wait_max;
    logic        r_starved;
    logic [15:0] w_cnt_inc;

    // Length of the current REQ run, counting this cycle. Saturates at 0xFFFF.
    assign w_cnt_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_wait_max <= '0;
            r_starved  <= 1'b0;
        end else if (r_state == S_REQ) begin
            r_wait_cnt <= w_issue ? 16'd0 : w_cnt_inc;
            if (w_cnt_inc > r_wait_max) begin
                r_wait_max <= w_cnt_inc;
            end
            if (w_cnt_inc >= 16'd256) begin
                r_starved <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign p1_wait_max = r_wait_max;
    assign p1_starved  = r_starved;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  D_addr;
    logic        D_rd, D_wr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_rvalid;
    logic        p1_req, p1_we;
    logic [7:0]  p1_addr;
    logic [15:0] p1_wdata, p1_rdata;
    logic        p1_gnt, p1_rvalid, p1_busy;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STARVE_MON_EN
    logic [15:0] p1_wait_max;
    logic        p1_starved;
`endif

    dmem_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_busy(p1_busy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STARVE_MON_EN
        , .p1_wait_max(p1_wait_max), .p1_starved(p1_starved)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: reads are captured every cycle and emerge LAT cycles later.
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_cpu[$];
    exp_t exp_p1[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Monitor: every rvalid pops one expected response and checks data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid) begin
            if (exp_cpu.size() == 0) begin
                chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            end else begin
                e = exp_cpu.pop_front();
                chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                chk("cpu_rvalid_cycle", cyc, e.cyc);
            end
        end
        if (p1_rvalid) begin
            if (exp_p1.size() == 0) begin
                chk("p1_rvalid_unexpected", 32'(p1_rvalid), 32'd0);
            end else begin
                e = exp_p1.pop_front();
                chk("p1_rdata", 32'(p1_rdata), 32'(e.data));
                chk("p1_rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gcount;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h20] = 16'h1234;
        rst = 1'b1; D_addr = 8'h55; D_rd = 1'b0; D_wr = 1'b1; cpu_wdata = 16'hDEAD;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 16'h0000;

        // Reset: the bus stays quiet even while a CPU write strobe is present.
        repeat (3) step();
        samp();
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p1_rdata", 32'(p1_rdata), 32'd0);
        chk("rst_p1_busy", 32'(p1_busy), 32'd0);
        step(); rst = 1'b0; D_wr = 1'b0;
        samp();
        chk("idle_mem_wr", 32'(mem_wr), 32'd0);

        // CPU write then read of 0x10
        step(); D_wr = 1'b1; D_addr = 8'h10; cpu_wdata = 16'hBEEF;
        samp();
        chk("cpu_wr_mem_wr", 32'(mem_wr), 32'd1);
        chk("cpu_wr_mem_rd", 32'(mem_rd), 32'd0);
        chk("cpu_wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("cpu_wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        step(); D_wr = 1'b0; D_rd = 1'b1;
        exp_cpu.push_back('{16'hBEEF, cyc + LAT});
        samp();
        chk("cpu_rd_mem_rd", 32'(mem_rd), 32'd1);
        step(); D_rd = 1'b0;
        samp();
        chk("cpu_idle_mem_rd", 32'(mem_rd), 32'd0);
        chk("cpu_idle_addr_hold", 32'(mem_addr), 32'h10);
        repeat (LAT + 2) step();

        // Port 1 read on an idle bus
        step(); p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        samp();
        chk("p1rd_no_gnt_in_idle", 32'(p1_gnt), 32'd0);
        step();
        samp();
        chk("p1rd_gnt", 32'(p1_gnt), 32'd1);
        chk("p1rd_mem_rd", 32'(mem_rd), 32'd1);
        chk("p1rd_mem_addr", 32'(mem_addr), 32'h20);
        chk("p1rd_busy_gnt", 32'(p1_busy), 32'd1);
        exp_p1.push_back('{16'h1234, cyc + LAT + 1});
        step(); p1_req = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            samp();
            chk("p1rd_busy_wait", 32'(p1_busy), 32'd1);
            step();
        end
        samp();
        chk("p1rd_busy_done", 32'(p1_busy), 32'd0);
        repeat (2) step();

        // Contention: five CPU reads while port 1 holds a write request
        step(); D_rd = 1'b1; D_addr = 8'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h30; p1_wdata = 16'h00AA;
        gcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            exp_cpu.push_back('{16'hBEEF, cyc + LAT});
            samp();
            if (p1_gnt) gcount++;
        end
        chk("cont_no_gnt_count", gcount, 0);
        step(); D_rd = 1'b0;
        samp();
        chk("cont_gnt", 32'(p1_gnt), 32'd1);
        chk("cont_mem_wr", 32'(mem_wr), 32'd1);
        chk("cont_mem_addr", 32'(mem_addr), 32'h30);
        chk("cont_mem_wdata", 32'(mem_wdata), 32'h00AA);
        step(); p1_req = 1'b0;
        samp();
        chk("cont_busy_after_wr", 32'(p1_busy), 32'd0);
        chk("cont_mem_30", 32'(mem[8'h30]), 32'h00AA);
        step(); D_rd = 1'b1; D_addr = 8'h30;
        exp_cpu.push_back('{16'h00AA, cyc + LAT});
        step(); D_rd = 1'b0;
        repeat (LAT + 2) step();

        // Both strobes: the write wins, and then the data reads back
        step(); D_rd = 1'b1; D_wr = 1'b1; D_addr = 8'h40; cpu_wdata = 16'h5555;
        samp();
        chk("both_mem_wr", 32'(mem_wr), 32'd1);
        chk("both_mem_rd", 32'(mem_rd), 32'd0);
        step(); D_wr = 1'b0;
        exp_cpu.push_back('{16'h5555, cyc + LAT});
        samp();
        chk("both_then_rd", 32'(mem_rd), 32'd1);
        step(); D_rd = 1'b0;
        repeat (LAT + 2) step();

        // p1_req dropped while in REQ: no access
        step(); p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        step(); D_rd = 1'b1; D_addr = 8'h10;
        exp_cpu.push_back('{16'hBEEF, cyc + LAT});
        samp();
        chk("drop_busy_req", 32'(p1_busy), 32'd1);
        step(); D_rd = 1'b0; p1_req = 1'b0;
        samp();
        chk("drop_no_gnt", 32'(p1_gnt), 32'd0);
        chk("drop_no_mem_rd", 32'(mem_rd), 32'd0);
        step();
        samp();
        chk("drop_busy_idle", 32'(p1_busy), 32'd0);
        repeat (LAT + 2) step();

        // Reset in the cycle after a port 1 grant
        step(); p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        n = 0;
        samp();
        while (!p1_gnt && n < 5) begin
            step(); samp(); n++;
        end
        chk("rstmid_gnt", 32'(p1_gnt), 32'd1);
        step(); p1_req = 1'b0; rst = 1'b1;
        samp();
        chk("rstmid_gnt_low", 32'(p1_gnt), 32'd0);
        chk("rstmid_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        step();
        samp();
        chk("rstmid_busy", 32'(p1_busy), 32'd0);
        chk("rstmid_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rstmid_p1_rdata", 32'(p1_rdata), 32'd0);
        chk("rstmid_mem_rd", 32'(mem_rd), 32'd0);
        step(); rst = 1'b0;
        repeat (LAT + 3) step();

        // A fresh request after reset is granted normally
        step(); p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h30;
        samp();
        chk("post_rst_no_gnt_idle", 32'(p1_gnt), 32'd0);
        step();
        samp();
        chk("post_rst_gnt", 32'(p1_gnt), 32'd1);
        exp_p1.push_back('{16'h00AA, cyc + LAT + 1});
        step(); p1_req = 1'b0;
        repeat (LAT + 4) step();

`ifdef DMEM_ARB_STARVE_MON_EN
        // Starvation: the CPU is busy for 305 cycles while port 1 waits
        step(); D_rd = 1'b1; D_addr = 8'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h50; p1_wdata = 16'h7777;
        gcount = 0;
        for (int i = 0; i < 305; i++) begin
            if (i > 0) step();
            exp_cpu.push_back('{16'hBEEF, cyc + LAT});
            samp();
            if (p1_gnt) gcount++;
        end
        chk("starve_no_gnt_count", gcount, 0);
        step(); D_rd = 1'b0;
        samp();
        chk("starve_gnt", 32'(p1_gnt), 32'd1);
        step(); p1_req = 1'b0;
        samp();
        chk("starve_flag", 32'(p1_starved), 32'd1);
        chk("starve_wait_max_ge_300", 32'(p1_wait_max >= 16'd300), 32'd1);
        repeat (5) step();
        samp();
        chk("starve_sticky", 32'(p1_starved), 32'd1);
        step(); rst = 1'b1;
        step();
        samp();
        chk("starve_rst_flag", 32'(p1_starved), 32'd0);
        chk("starve_rst_max", 32'(p1_wait_max), 32'd0);
        step(); rst = 1'b0;
        repeat (3) step();
`endif

        samp();
        chk("cpu_queue_drained", exp_cpu.size(), 0);
        chk("p1_queue_drained", exp_p1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU control unit's D_addr/D_rd/D_wr port (port 0) and a secondary requester (port 1: loader/debug/DMA) using a req/gnt handshake.
- Port 0 has absolute priority and zero added latency; the control unit has no stall input.
- Port 1 uses only idle memory cycles. A small FSM tracks its single outstanding access and routes read data back through a latency-matched tag pipeline.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, memory address width; matches D_addr.
- RD_LAT, 1, memory read latency in cycles, range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- D_addr  in  ADDR_W  port 0 address.
- D_rd  in  1  port 0 read strobe.
- D_wr  in  1  port 0 write strobe.
- cpu_wdata  in  DATA_W  port 0 write data.
- cpu_rdata  out  DATA_W  port 0 read data.
- cpu_rvalid  out  1  port 0 read data valid.
- p1_req  in  1  port 1 request; held until p1_gnt.
- p1_we  in  1  port 1 write (1) or read (0).
- p1_addr  in  ADDR_W  port 1 address.
- p1_wdata  in  DATA_W  port 1 write data.
- p1_gnt  out  1  one-cycle pulse when the port 1 access is issued.
- p1_rdata  out  DATA_W  port 1 read data, registered.
- p1_rvalid  out  1  one-cycle pulse, p1_rdata valid.
- p1_busy  out  1  port 1 FSM not in IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read.
- mem_wr  out  1  memory write.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all registered outputs 0 (p1_gnt, p1_rvalid, p1_rdata, cpu_rvalid, p1_busy); FSM in IDLE; tag pipeline cleared.
- Memory outputs while rst=1: mem_rd=0 and mem_wr=0.
- cpu_active = D_rd | D_wr. When cpu_active=1, the memory bus is driven combinationally from port 0 in the same cycle:
  - mem_wr = D_wr.
  - mem_rd = D_rd & ~D_wr; if both strobes are high, the write wins and the read is dropped.
- Port 1 issue condition: FSM in REQ, p1_req=1, cpu_active=0.
  - In that cycle the memory bus is driven from port 1 and p1_gnt=1.
  - p1_gnt is a combinational pulse in the issue cycle.
- When neither port issues, mem_rd=0 and mem_wr=0; mem_addr and mem_wdata hold their last driven values. No glitch requirement applies.
- FSM states:
  - IDLE: p1_req=1 -> REQ (one cycle of arbitration latency).
  - REQ: blocked by the CPU -> stay in REQ. Issue with p1_we=1 -> IDLE. Issue with p1_we=0 -> RDWAIT.
  - RDWAIT: tag returns -> IDLE; p1_rvalid pulses and p1_rdata captures mem_rdata.
- Port 1 has at most one outstanding access. No new grant is given in RDWAIT.
- p1_req dropping in REQ before a grant returns the FSM to IDLE with no access.
- Tag pipeline: a shift register of depth RD_LAT holding {valid, owner}. An entry is pushed on every mem_rd. At the output stage:
  - owner 0: cpu_rvalid=1 and cpu_rdata=mem_rdata (cpu_rdata combinational passthrough).
  - owner 1: p1_rvalid=1 on the next edge, with p1_rdata registered. Port 1 read latency is RD_LAT+1 from p1_gnt.
- Starvation: port 1 can wait indefinitely while the CPU accesses memory every cycle. This is acceptable by design.
- Reset mid-operation: in-flight tags are discarded, with no rvalid for them. The FSM returns to IDLE. Port 1 must re-request.
- Write then read of the same address in consecutive cycles follows memory semantics; no forwarding is done inside the arbiter.

Optional Feature:
- Macro: DMEM_ARB_STARVE_MON_EN.
- Defined: adds output p1_wait_max [15:0], the maximum consecutive cycles spent in REQ since reset. It saturates at 0xFFFF. The running count clears on every grant.
  - Adds output p1_starved, a sticky flag set when the running count reaches 256. It is cleared only by rst.
- Undefined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Test Plan:
- CPU-only traffic: D_wr=1, D_addr=0x10, cpu_wdata=0xBEEF, then D_rd=1 at 0x10 -> mem_wr in the same cycle; cpu_rvalid=1 with cpu_rdata=0xBEEF exactly RD_LAT cycles after the read.
- Port 1 read with the bus idle: p1_req=1, p1_we=0, p1_addr=0x20 (memory holds 0x1234) -> p1_gnt one cycle after req; p1_rvalid=1 with p1_rdata=0x1234 RD_LAT+1 cycles after gnt; p1_busy=1 throughout.
- Contention: CPU reads on 5 consecutive cycles while p1_req is held with a write of 0x00AA to 0x30 -> no p1_gnt during those cycles; p1_gnt in the first idle cycle; memory[0x30]=0x00AA.
- Both strobes: D_rd=1 and D_wr=1 together -> mem_wr=1, mem_rd=0, no cpu_rvalid.
- Reset mid-read: issue a port 1 read, then assert rst in the cycle after gnt -> no p1_rvalid; all outputs 0; FSM in IDLE; the next request is granted normally.
- Starvation monitor (with DMEM_ARB_STARVE_MON_EN defined): CPU busy for 300 cycles with p1_req held -> p1_starved=1 and p1_wait_max>=300 after the grant; p1_starved stays 1 until rst.
